// File: rtl/multiport_reorder_buffer_if.sv
// Bundle of the allocate, result-write, forwarding and retire signals of the reorder buffer.
// The slave modport is the buffer itself; master is the issue/execute/writeback side.
interface multiport_reorder_buffer_if #(
  parameter int DEPTH      = 32,
  parameter int WR_PORTS   = 3,
  parameter int SRC_PORTS  = 2,
  parameter int DATA_WIDTH = 32
) ();
  localparam int AW = $clog2(DEPTH);

  logic                                 alloc_i;
  logic [4:0]                           alloc_reg_i;
  logic [AW-1:0]                        alloc_tag_o;
  logic                                 full_o;
  logic                                 empty_o;
  logic [AW:0]                          count_o;

  logic [WR_PORTS-1:0]                  wr_valid_i;
  logic [WR_PORTS-1:0][AW-1:0]          wr_tag_i;
  logic [WR_PORTS-1:0][DATA_WIDTH-1:0]  wr_data_i;
  logic [WR_PORTS-1:0]                  wr_exc_i;
  logic [WR_PORTS-1:0][4:0]             wr_vector_i;

  logic [SRC_PORTS-1:0][4:0]            fwd_src_i;
  logic [SRC_PORTS-1:0]                 fwd_hit_o;
  logic [SRC_PORTS-1:0]                 fwd_ready_o;
  logic [SRC_PORTS-1:0][DATA_WIDTH-1:0] fwd_data_o;

  logic                                 ret_valid_o;
  logic                                 ret_ready_i;
  logic [4:0]                           ret_reg_o;
  logic [DATA_WIDTH-1:0]                ret_data_o;
  logic                                 ret_exc_o;
  logic [4:0]                           ret_vector_o;
  logic [AW-1:0]                        ret_tag_o;

  modport slave (
    input  alloc_i, alloc_reg_i, wr_valid_i, wr_tag_i, wr_data_i, wr_exc_i, wr_vector_i,
           fwd_src_i, ret_ready_i,
    output alloc_tag_o, full_o, empty_o, count_o, fwd_hit_o, fwd_ready_o, fwd_data_o,
           ret_valid_o, ret_reg_o, ret_data_o, ret_exc_o, ret_vector_o, ret_tag_o
  );

  modport master (
    output alloc_i, alloc_reg_i, wr_valid_i, wr_tag_i, wr_data_i, wr_exc_i, wr_vector_i,
           fwd_src_i, ret_ready_i,
    input  alloc_tag_o, full_o, empty_o, count_o, fwd_hit_o, fwd_ready_o, fwd_data_o,
           ret_valid_o, ret_reg_o, ret_data_o, ret_exc_o, ret_vector_o, ret_tag_o
  );
endinterface

// File: rtl/multiport_reorder_buffer.sv
// In-order retirement buffer: tags allocated in program order, results written out of order
// by up to WR_PORTS units, youngest-producer operand forwarding, strict in-order retire.
module multiport_reorder_buffer #(
  parameter int DEPTH      = 32,
  parameter int WR_PORTS   = 3,
  parameter int SRC_PORTS  = 2,
  parameter int DATA_WIDTH = 32
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic flush_i,
  multiport_reorder_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]           head_q, tail_q;
  logic [DEPTH-1:0]      alloc_q, written_q, exc_q;
  logic [4:0]            reg_q  [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [4:0]            vec_q  [DEPTH];

  logic [AW-1:0]         headIdx, tailIdx;
  logic                  isEmpty, isFull, retValid, allocFire, retireFire;

  logic [DEPTH-1:0]      wrEn, wrExc;
  logic [DATA_WIDTH-1:0] wrData [DEPTH];
  logic [4:0]            wrVec  [DEPTH];

  logic [AW-1:0]         ageIdx [DEPTH];
  logic [AW-1:0]         fwdSel [SRC_PORTS];
  logic [SRC_PORTS-1:0]  fwdFound, fwdReady;
  logic [SRC_PORTS-1:0][DATA_WIDTH-1:0] fwdData;

  assign headIdx    = head_q[AW-1:0];
  assign tailIdx    = tail_q[AW-1:0];
  assign isEmpty    = (head_q == tail_q);
  assign isFull     = (head_q[AW] != tail_q[AW]) && (headIdx == tailIdx);
  assign retValid   = !isEmpty && written_q[headIdx];
  assign allocFire  = bus.alloc_i && !isFull;
  assign retireFire = retValid && bus.ret_ready_i;

  assign bus.empty_o      = isEmpty;
  assign bus.full_o       = isFull;
  assign bus.count_o      = tail_q - head_q;
  assign bus.alloc_tag_o  = tailIdx;
  assign bus.ret_valid_o  = retValid;
  assign bus.ret_reg_o    = reg_q[headIdx];
  assign bus.ret_data_o   = data_q[headIdx];
  assign bus.ret_exc_o    = exc_q[headIdx];
  assign bus.ret_vector_o = vec_q[headIdx];
  assign bus.ret_tag_o    = headIdx;
  assign bus.fwd_hit_o    = fwdFound;
  assign bus.fwd_ready_o  = fwdReady;
  assign bus.fwd_data_o   = fwdData;

  // Ports are scanned from highest to lowest so the lowest-indexed port on a tag wins.
  always_comb begin
    wrEn  = '0;
    wrExc = '0;
    for (int e = 0; e < DEPTH; e++) begin
      wrData[e] = '0;
      wrVec[e]  = '0;
      for (int p = WR_PORTS - 1; p >= 0; p--) begin
        if (bus.wr_valid_i[p] && (bus.wr_tag_i[p] == AW'(e))) begin
          wrEn[e]   = alloc_q[e] && !written_q[e];
          wrData[e] = bus.wr_data_i[p];
          wrExc[e]  = bus.wr_exc_i[p];
          wrVec[e]  = bus.wr_vector_i[p];
        end
      end
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_age
    assign ageIdx[i] = headIdx + AW'(i);
  end

  // Walk oldest to youngest; the last match left standing is the youngest producer.
  always_comb begin
    fwdFound = '0;
    fwdReady = '0;
    fwdData  = '0;
    for (int s = 0; s < SRC_PORTS; s++) begin
      fwdSel[s] = '0;
      for (int i = 0; i < DEPTH; i++) begin
        if (alloc_q[ageIdx[i]] && (bus.fwd_src_i[s] != 5'd0) &&
            (reg_q[ageIdx[i]] == bus.fwd_src_i[s])) begin
          fwdFound[s] = 1'b1;
          fwdSel[s]   = ageIdx[i];
        end
      end
      if (fwdFound[s] && written_q[fwdSel[s]]) begin
        fwdReady[s] = 1'b1;
        fwdData[s]  = data_q[fwdSel[s]];
      end
    end
  end

  // Payload arrays are cleared on reset so the retire fields never show X.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q    <= '0;
      tail_q    <= '0;
      alloc_q   <= '0;
      written_q <= '0;
      exc_q     <= '0;
      for (int e = 0; e < DEPTH; e++) begin
        reg_q[e]  <= '0;
        data_q[e] <= '0;
        vec_q[e]  <= '0;
      end
    end else if (flush_i) begin
      head_q    <= '0;
      tail_q    <= '0;
      alloc_q   <= '0;
      written_q <= '0;
    end else begin
      for (int e = 0; e < DEPTH; e++) begin
        if (wrEn[e]) begin
          written_q[e] <= 1'b1;
          data_q[e]    <= wrData[e];
          exc_q[e]     <= wrExc[e];
          vec_q[e]     <= wrVec[e];
        end
      end
      if (allocFire) begin
        alloc_q[tailIdx]   <= 1'b1;
        written_q[tailIdx] <= 1'b0;
        reg_q[tailIdx]     <= bus.alloc_reg_i;
        tail_q             <= tail_q + (AW+1)'(1);
      end
      if (retireFire) begin
        alloc_q[headIdx]   <= 1'b0;
        written_q[headIdx] <= 1'b0;
        head_q             <= head_q + (AW+1)'(1);
      end
    end
  end
endmodule

// File: tb/tb_multiport_reorder_buffer.sv
// Directed-vector bench for multiport_reorder_buffer with DEPTH=4 so wrap and full are reachable.
// Each vector drives inputs, checks outputs just before the next rising edge, then clocks.
module tb_multiport_reorder_buffer;
  localparam int DEPTH      = 4;
  localparam int WR_PORTS   = 3;
  localparam int SRC_PORTS  = 2;
  localparam int DATA_WIDTH = 32;

  typedef struct packed {
    logic             flush;
    logic             alloc;
    logic [4:0]       allocReg;
    logic [2:0]       wrValid;
    logic [2:0][1:0]  wrTag;
    logic [2:0][31:0] wrData;
    logic [2:0]       wrExc;
    logic [4:0]       wrVec;
    logic [4:0]       src0;
    logic [4:0]       src1;
    logic             retReady;
    logic             eEmpty;
    logic             eFull;
    logic [2:0]       eCount;
    logic [1:0]       eTag;
    logic             eRv;
    logic [4:0]       eReg;
    logic [31:0]      eData;
    logic             eExc;
    logic [4:0]       eVec;
    logic [1:0]       eRtag;
    logic [1:0]       eHit;
    logic [1:0]       eRdy;
    logic [31:0]      eF0;
    logic [31:0]      eF1;
  } vecT;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  int   vecCount  = 0;
  int   missCount = 0;

  always #5 clk = ~clk;

  multiport_reorder_buffer_if #(
    .DEPTH(DEPTH), .WR_PORTS(WR_PORTS), .SRC_PORTS(SRC_PORTS), .DATA_WIDTH(DATA_WIDTH)
  ) robIf ();

  multiport_reorder_buffer #(
    .DEPTH(DEPTH), .WR_PORTS(WR_PORTS), .SRC_PORTS(SRC_PORTS), .DATA_WIDTH(DATA_WIDTH)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .flush_i(flush),
    .bus    (robIf)
  );

  function automatic string fmt(vecT x);
    return $sformatf("empty=%b full=%b count=%0d tag=%0d rv=%b reg=%0d data=%h exc=%b vec=%0d rtag=%0d hit=%b rdy=%b f0=%h f1=%h",
                     x.eEmpty, x.eFull, x.eCount, x.eTag, x.eRv, x.eReg, x.eData, x.eExc,
                     x.eVec, x.eRtag, x.eHit, x.eRdy, x.eF0, x.eF1);
  endfunction

  task automatic driveInputs(input vecT v);
    flush                = v.flush;
    robIf.alloc_i        = v.alloc;
    robIf.alloc_reg_i    = v.allocReg;
    robIf.wr_valid_i     = v.wrValid;
    robIf.wr_tag_i       = v.wrTag;
    robIf.wr_data_i      = v.wrData;
    robIf.wr_exc_i       = v.wrExc;
    robIf.wr_vector_i    = {3{v.wrVec}};
    robIf.fwd_src_i      = {v.src1, v.src0};
    robIf.ret_ready_i    = v.retReady;
  endtask

  // Head fields are only meaningful while a retire is offered, so they are masked otherwise.
  task automatic checkOutput(input string name, input vecT v);
    vecT act, want;
    want       = v;
    act        = v;
    act.eEmpty = robIf.empty_o;
    act.eFull  = robIf.full_o;
    act.eCount = robIf.count_o;
    act.eTag   = robIf.alloc_tag_o;
    act.eRv    = robIf.ret_valid_o;
    act.eReg   = robIf.ret_reg_o;
    act.eData  = robIf.ret_data_o;
    act.eExc   = robIf.ret_exc_o;
    act.eVec   = robIf.ret_vector_o;
    act.eRtag  = robIf.ret_tag_o;
    act.eHit   = robIf.fwd_hit_o;
    act.eRdy   = robIf.fwd_ready_o;
    act.eF0    = robIf.fwd_data_o[0];
    act.eF1    = robIf.fwd_data_o[1];
    if (!v.eRv) begin
      act.eReg  = '0; act.eData = '0; act.eExc = '0; act.eVec = '0; act.eRtag = '0;
      want.eReg = '0; want.eData = '0; want.eExc = '0; want.eVec = '0; want.eRtag = '0;
    end
    vecCount++;
    if (act !== want) begin
      missCount++;
      $display("[TB] FAIL %s: got %s ; want %s", name, fmt(act), fmt(want));
    end
  endtask

  task automatic applyStimulus(input string name, input vecT v);
    driveInputs(v);
    #1;
    checkOutput(name, v);
    @(negedge clk);
  endtask

  vecT tbl[$];
  vecT v;
  int  base;

  initial begin
    // Out-of-order completion and in-order retire
    tbl.push_back(vecT'{alloc:1, allocReg:5, eEmpty:1, default:0});
    tbl.push_back(vecT'{alloc:1, allocReg:6, eCount:1, eTag:1, default:0});
    tbl.push_back(vecT'{alloc:1, allocReg:7, eCount:2, eTag:2, default:0});
    tbl.push_back(vecT'{wrValid:3'b100, wrTag:{2'd2,2'd0,2'd0}, wrData:{32'hC,32'h0,32'h0}, eCount:3, eTag:3, default:0});
    tbl.push_back(vecT'{wrValid:3'b001, wrTag:{2'd0,2'd0,2'd0}, wrData:{32'h0,32'h0,32'hA}, eCount:3, eTag:3, default:0});
    tbl.push_back(vecT'{wrValid:3'b010, wrTag:{2'd0,2'd1,2'd0}, wrData:{32'h0,32'hB,32'h0}, eCount:3, eTag:3, eRv:1, eReg:5, eData:32'hA, eRtag:0, default:0});
    tbl.push_back(vecT'{retReady:1, eCount:3, eTag:3, eRv:1, eReg:5, eData:32'hA, eRtag:0, default:0});
    tbl.push_back(vecT'{retReady:1, eCount:2, eTag:3, eRv:1, eReg:6, eData:32'hB, eRtag:1, default:0});
    tbl.push_back(vecT'{retReady:1, eCount:1, eTag:3, eRv:1, eReg:7, eData:32'hC, eRtag:2, default:0});
    tbl.push_back(vecT'{eEmpty:1, eTag:3, default:0});
    // Forwarding: youngest producer of reg 9 wins
    tbl.push_back(vecT'{alloc:1, allocReg:9, src0:9, eEmpty:1, eTag:3, default:0});
    tbl.push_back(vecT'{alloc:1, allocReg:9, src0:9, eCount:1, eTag:0, eHit:2'b01, default:0});
    tbl.push_back(vecT'{wrValid:3'b001, wrTag:{2'd0,2'd0,2'd3}, wrData:{32'h0,32'h0,32'h11}, src0:9, src1:9, eCount:2, eTag:1, eHit:2'b11, default:0});
    tbl.push_back(vecT'{src0:9, eCount:2, eTag:1, eRv:1, eReg:9, eData:32'h11, eRtag:3, eHit:2'b01, default:0});
    tbl.push_back(vecT'{wrValid:3'b010, wrTag:{2'd0,2'd0,2'd0}, wrData:{32'h0,32'h22,32'h0}, wrExc:3'b010, wrVec:7, src0:9, eCount:2, eTag:1, eRv:1, eReg:9, eData:32'h11, eRtag:3, eHit:2'b01, default:0});
    tbl.push_back(vecT'{src0:9, eCount:2, eTag:1, eRv:1, eReg:9, eData:32'h11, eRtag:3, eHit:2'b01, eRdy:2'b01, eF0:32'h22, default:0});
    tbl.push_back(vecT'{retReady:1, src0:9, eCount:2, eTag:1, eRv:1, eReg:9, eData:32'h11, eRtag:3, eHit:2'b01, eRdy:2'b01, eF0:32'h22, default:0});
    tbl.push_back(vecT'{src0:9, eCount:1, eTag:1, eRv:1, eReg:9, eData:32'h22, eExc:1, eVec:7, eRtag:0, eHit:2'b01, eRdy:2'b01, eF0:32'h22, default:0});
    tbl.push_back(vecT'{retReady:1, src0:9, eCount:1, eTag:1, eRv:1, eReg:9, eData:32'h22, eExc:1, eVec:7, eRtag:0, eHit:2'b01, eRdy:2'b01, eF0:32'h22, default:0});
    // Write conflicts, duplicate write, write to an unallocated tag
    tbl.push_back(vecT'{alloc:1, allocReg:1, src0:9, eEmpty:1, eTag:1, default:0});
    tbl.push_back(vecT'{alloc:1, allocReg:2, eCount:1, eTag:2, default:0});
    tbl.push_back(vecT'{alloc:1, allocReg:3, eCount:2, eTag:3, default:0});
    tbl.push_back(vecT'{wrValid:3'b101, wrTag:{2'd3,2'd0,2'd3}, wrData:{32'h2,32'h0,32'h1}, src0:3, eCount:3, eTag:0, eHit:2'b01, default:0});
    tbl.push_back(vecT'{wrValid:3'b010, wrTag:{2'd0,2'd3,2'd0}, wrData:{32'h0,32'h55,32'h0}, src0:3, eCount:3, eTag:0, eHit:2'b01, eRdy:2'b01, eF0:32'h1, default:0});
    tbl.push_back(vecT'{wrValid:3'b001, wrTag:{2'd0,2'd0,2'd0}, wrData:{32'h0,32'h0,32'h66}, src0:3, eCount:3, eTag:0, eHit:2'b01, eRdy:2'b01, eF0:32'h1, default:0});
    tbl.push_back(vecT'{wrValid:3'b001, wrTag:{2'd0,2'd0,2'd1}, wrData:{32'h0,32'h0,32'h77}, src0:3, eCount:3, eTag:0, eHit:2'b01, eRdy:2'b01, eF0:32'h1, default:0});
    tbl.push_back(vecT'{alloc:1, allocReg:4, src0:3, src1:1, eCount:3, eTag:0, eRv:1, eReg:1, eData:32'h77, eRtag:1, eHit:2'b11, eRdy:2'b11, eF0:32'h1, eF1:32'h77, default:0});
    tbl.push_back(vecT'{src0:3, src1:4, eFull:1, eCount:4, eTag:1, eRv:1, eReg:1, eData:32'h77, eRtag:1, eHit:2'b11, eRdy:2'b01, eF0:32'h1, default:0});
    tbl.push_back(vecT'{retReady:1, src0:3, src1:4, eFull:1, eCount:4, eTag:1, eRv:1, eReg:1, eData:32'h77, eRtag:1, eHit:2'b11, eRdy:2'b01, eF0:32'h1, default:0});
    tbl.push_back(vecT'{wrValid:3'b100, wrTag:{2'd2,2'd0,2'd0}, wrData:{32'h88,32'h0,32'h0}, eCount:3, eTag:1, default:0});

    rst = 1'b1;
    driveInputs('0);
    #1;
    checkOutput("reset", vecT'{eEmpty:1, default:0});
    #2;
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < tbl.size(); i++) applyStimulus($sformatf("table[%0d]", i), tbl[i]);

    // Flush wins over a same-cycle alloc, write and retire
    applyStimulus("flushCycle", vecT'{flush:1, alloc:1, allocReg:10, wrValid:3'b001, wrTag:{2'd0,2'd0,2'd0}, wrData:{32'h0,32'h0,32'h33}, retReady:1, eCount:3, eTag:1, eRv:1, eReg:2, eData:32'h88, eRtag:2, default:0});
    applyStimulus("afterFlush", vecT'{src0:4, eEmpty:1, default:0});

    // Fill to full, alloc+retire while full, wrap of the tail
    for (int k = 0; k < 4; k++) begin
      v = '0; v.alloc = 1'b1; v.allocReg = 5'(20 + k);
      v.eEmpty = (k == 0); v.eCount = 3'(k); v.eTag = 2'(k);
      applyStimulus("wrapFill", v);
    end
    applyStimulus("wrapFull", vecT'{wrValid:3'b001, wrTag:{2'd0,2'd0,2'd0}, wrData:{32'h0,32'h0,32'h2000}, eFull:1, eCount:4, eTag:0, default:0});
    applyStimulus("allocWhileFull", vecT'{alloc:1, allocReg:30, retReady:1, eFull:1, eCount:4, eTag:0, eRv:1, eReg:20, eData:32'h2000, eRtag:0, default:0});
    applyStimulus("wrapTag", vecT'{alloc:1, allocReg:31, eCount:3, eTag:0, default:0});
    applyStimulus("wrapOoo", vecT'{wrValid:3'b111, wrTag:{2'd1,2'd2,2'd3}, wrData:{32'h2001,32'h2002,32'h2003}, eFull:1, eCount:4, eTag:1, default:0});
    applyStimulus("wrapOld", vecT'{wrValid:3'b001, wrTag:{2'd0,2'd0,2'd0}, wrData:{32'h0,32'h0,32'h2004}, eFull:1, eCount:4, eTag:1, eRv:1, eReg:21, eData:32'h2001, eRtag:1, default:0});
    applyStimulus("wrapRet0", vecT'{retReady:1, eFull:1, eCount:4, eTag:1, eRv:1, eReg:21, eData:32'h2001, eRtag:1, default:0});
    applyStimulus("wrapRet1", vecT'{retReady:1, eCount:3, eTag:1, eRv:1, eReg:22, eData:32'h2002, eRtag:2, default:0});
    applyStimulus("wrapRet2", vecT'{retReady:1, eCount:2, eTag:1, eRv:1, eReg:23, eData:32'h2003, eRtag:3, default:0});
    applyStimulus("wrapRet3", vecT'{retReady:1, eCount:1, eTag:1, eRv:1, eReg:31, eData:32'h2004, eRtag:0, default:0});

    // Three more full fill/drain rounds, each wrapping the pointers once
    base = 1;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 4; k++) begin
        v = '0; v.alloc = 1'b1; v.allocReg = 5'(8 * r + k + 1);
        v.eEmpty = (k == 0); v.eCount = 3'(k); v.eTag = 2'((base + k) % 4);
        applyStimulus("roundFill", v);
      end
      v = '0; v.wrValid = 3'b111; v.eFull = 1'b1; v.eCount = 3'd4; v.eTag = 2'(base);
      for (int p = 0; p < 3; p++) begin
        v.wrTag[p]  = 2'((base + 3 - p) % 4);
        v.wrData[p] = 32'h3000 + 32'(16 * r + 3 - p);
      end
      applyStimulus("roundWrite", v);
      v = '0; v.wrValid = 3'b001; v.wrTag[0] = 2'(base); v.wrData[0] = 32'h3000 + 32'(16 * r);
      v.eFull = 1'b1; v.eCount = 3'd4; v.eTag = 2'(base);
      applyStimulus("roundWriteHead", v);
      for (int k = 0; k < 4; k++) begin
        v = '0; v.retReady = 1'b1; v.eFull = (k == 0); v.eCount = 3'(4 - k); v.eTag = 2'(base);
        v.eRv = 1'b1; v.eReg = 5'(8 * r + k + 1); v.eData = 32'h3000 + 32'(16 * r + k);
        v.eRtag = 2'((base + k) % 4);
        applyStimulus("roundRetire", v);
      end
    end

    // Asynchronous reset between edges with two written entries
    applyStimulus("preRstA", vecT'{alloc:1, allocReg:12, eEmpty:1, eTag:1, default:0});
    applyStimulus("preRstB", vecT'{alloc:1, allocReg:13, eCount:1, eTag:2, default:0});
    applyStimulus("preRstW", vecT'{wrValid:3'b011, wrTag:{2'd0,2'd2,2'd1}, wrData:{32'h0,32'h13,32'h12}, eCount:2, eTag:3, default:0});
    applyStimulus("preRstChk", vecT'{src0:12, eCount:2, eTag:3, eRv:1, eReg:12, eData:32'h12, eRtag:1, eHit:2'b01, eRdy:2'b01, eF0:32'h12, default:0});
    driveInputs(vecT'{src0:12, default:0});
    #2;
    rst = 1'b1;
    #1;
    checkOutput("asyncRst", vecT'{src0:12, eEmpty:1, default:0});
    @(negedge clk);
    rst = 1'b0;
    applyStimulus("postRstAlloc", vecT'{alloc:1, allocReg:14, src0:14, eEmpty:1, eTag:0, default:0});
    applyStimulus("postRstChk", vecT'{src0:14, eCount:1, eTag:1, eHit:2'b01, default:0});

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end
endmodule
